ber_symbol_checker: RTL and testbench
=====================================

Name: ber_symbol_checker

Overview:
- Receive-side checker on the TX polyphase filter output: decimates the S(8,7) oversampled stream to one sample per symbol at a selectable phase and makes a hard sign decision.
- Aligns the decisions against the PRBS reference bits fed to the filter input, then counts bits and bit errors.
- Sits directly downstream of the polyphase filter, driven by the same phase counter and the same data-enable strobe.

Parameters:
- NBT_IN, 8, total bits of i_os_data (S(NBT_IN,NBT_IN-1)).
- OS, 4, oversampling factor; phase width = $clog2(OS).
- MAX_DELAY, 512, number of candidate alignment delays; delay width NB_DLY = $clog2(MAX_DELAY).
- ALIGN_WIN, 128, symbols compared per candidate delay.
- NB_CNT, 64, width of bit and error counters.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  reset.
- i_enable  in  1  global enable; when low, all state holds.
- i_os_data  in  NBT_IN  signed filter output sample.
- i_phase  in  $clog2(OS)  phase index of the current i_os_data sample.
- i_phase_sel  in  $clog2(OS)  sampling phase used for decisions.
- i_ref_bit  in  1  PRBS bit presented to the filter input.
- i_ref_valid  in  1  symbol strobe: i_ref_bit is valid; the filter shifts on the same strobe.
- i_clear  in  1  restart alignment and clear counters.
- o_locked  out  1  alignment achieved.
- o_delay  out  NB_DLY  current or locked candidate delay.
- o_bit_count  out  NB_CNT  bits compared while locked.
- o_err_count  out  NB_CNT  errors while locked.

Behaviour:
- Reset: i_reset is synchronous, active-high, on clock clk. Reset takes priority over everything. All outputs are 0, the reference line is 0, state = ALIGN, candidate d = 0, window counter and window error counter are 0.
- Qualifier: en = i_enable. When en = 0, every register holds.
- Decision strobe: dstb = en & (i_phase == i_phase_sel). Decision bit = i_os_data[NBT_IN-1] (negative → 1, which matches the filter's 1 → -coeff mapping).
- Reference line: MAX_DELAY-1 bit shift register. On en & i_ref_valid, i_ref_bit enters ref[1] and ref[k] ← ref[k-1].
- Compared reference for candidate d: i_ref_bit when d = 0, otherwise ref[d], taken before the same-cycle shift.
- ALIGN state, on each dstb:
  - Window counter increments; the window error counter adds (decision ^ reference).
  - At the ALIGN_WIN-th strobe, with the current mismatch included:
    - If total errors = 0 → go to LOCKED.
    - Otherwise d ← d+1, wrapping from MAX_DELAY-1 to 0.
  - Window counter and window error counter clear at every window end.
- LOCKED state, on each dstb:
  - o_bit_count += 1.
  - o_err_count += mismatch.
  - Both counters saturate at all-ones and hold there.
- No automatic lock loss. i_clear returns the block to ALIGN.
- i_clear (when i_reset = 0) takes priority over dstb in the same cycle:
  - State = ALIGN, d = 0.
  - Window counter, window error counter and output counters → 0.
  - o_locked → 0.
  - The reference line is not cleared.
- Output registering: o_locked, o_delay and the counters are registered. o_locked rises on the clock edge that ends the zero-error window; o_delay equals d at all times.
- The first LOCKED count occurs on the dstb after the lock edge; the window-end strobe itself is not counted.
- Arithmetic: mismatch is a 1-bit XOR. Counters use unsigned NB_CNT-bit adds with a saturation check on all-ones.
- Boundary cases:
  - i_phase_sel changed mid-operation: takes effect on the next sample compare; no flush.
  - i_ref_valid without dstb (or the reverse): the reference shifts and the decision is not compared (or vice versa). Normal operation keeps them coincident.

Test Plan:
- Reset mid-LOCKED (counters nonzero), i_reset = 1 for one cycle → all outputs 0 on the next edge; state ALIGN, d = 0.
- PRBS9 reference, decisions = reference delayed by 3 symbols, clean signs, i_phase_sel = 2 → ALIGN fails at d = 0,1,2 and o_locked rises after 4×128 = 512 dstb with o_delay = 3. Then 1000 further strobes → o_bit_count = 1000, o_err_count = 0.
- Locked, then force the sign of every 10th decision wrong for 1000 strobes → o_bit_count = 1000, o_err_count = 100; o_locked stays 1.
- Reference with no matching delay (decisions inverted) → o_locked stays 0; o_delay wraps 511 → 0 after 512×128 strobes.
- Locked with o_bit_count preloaded near all-ones (force) → reaches all-ones and holds; o_err_count is unaffected.
- i_clear asserted on a dstb cycle while locked → next edge: o_locked = 0, o_delay = 0, counters 0; that strobe is not counted. i_enable = 0 for 50 cycles → all outputs frozen.

Source files
------------

// File: rtl/ber_symbol_checker.sv
// ber_symbol_checker: decimates the oversampled filter output to one hard decision per symbol,
// searches for the reference delay with a zero-error window, then counts bits and errors.
module ber_symbol_checker #(
    parameter int NBT_IN    = 8,
    parameter int OS        = 4,
    parameter int MAX_DELAY = 512,
    parameter int ALIGN_WIN = 128,
    parameter int NB_CNT    = 64,
    localparam int NB_PH    = $clog2(OS),
    localparam int NB_DLY   = $clog2(MAX_DELAY)
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic signed [NBT_IN-1:0] i_os_data,
    input  logic [NB_PH-1:0]         i_phase,
    input  logic [NB_PH-1:0]         i_phase_sel,
    input  logic                     i_ref_bit,
    input  logic                     i_ref_valid,
    input  logic                     i_clear,
    output logic                     o_locked,
    output logic [NB_DLY-1:0]        o_delay,
    output logic [NB_CNT-1:0]        o_bit_count,
    output logic [NB_CNT-1:0]        o_err_count
);
    localparam int NB_WIN  = $clog2(ALIGN_WIN);
    localparam int NB_WERR = $clog2(ALIGN_WIN + 1);

    typedef enum logic {ALIGN, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [NB_DLY-1:0]   dly_q, dly_d;
    logic [NB_WIN-1:0]   win_q, win_d;
    logic [NB_WERR-1:0]  werr_q, werr_d;
    logic [NB_CNT-1:0]   bits_q, bits_d, errs_q, errs_d;
    logic [MAX_DELAY-1:1] ref_line;
    logic [MAX_DELAY-1:0] taps;
    logic                en, dstb, mismatch, win_end, unused_bits;

    assign en          = i_enable;
    assign dstb        = en & (i_phase == i_phase_sel);
    // Tap 0 is the live reference bit; taps 1.. are the line before this cycle's shift.
    assign taps        = {ref_line, i_ref_bit};
    assign mismatch    = i_os_data[NBT_IN-1] ^ taps[dly_q];
    assign win_end     = win_q == NB_WIN'(ALIGN_WIN - 1);
    assign unused_bits = ^i_os_data[NBT_IN-2:0];

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        win_d   = win_q;
        werr_d  = werr_q;
        bits_d  = bits_q;
        errs_d  = errs_q;
        if (i_clear) begin
            state_d = ALIGN;
            dly_d   = '0;
            win_d   = '0;
            werr_d  = '0;
            bits_d  = '0;
            errs_d  = '0;
        end else if (dstb && state_q == ALIGN) begin
            win_d  = win_q + NB_WIN'(1);
            werr_d = werr_q + NB_WERR'(mismatch);
            if (win_end) begin
                win_d  = '0;
                werr_d = '0;
                if (werr_q == '0 && !mismatch)
                    state_d = LOCKED;
                else
                    dly_d = (dly_q == NB_DLY'(MAX_DELAY - 1)) ? '0 : dly_q + NB_DLY'(1);
            end
        end else if (dstb) begin
            bits_d = &bits_q ? bits_q : bits_q + NB_CNT'(1);
            errs_d = (&errs_q || !mismatch) ? errs_q : errs_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= ALIGN;
            dly_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            bits_q   <= '0;
            errs_q   <= '0;
            ref_line <= '0;
        end else if (en) begin
            state_q <= state_d;
            dly_q   <= dly_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            bits_q  <= bits_d;
            errs_q  <= errs_d;
            if (i_ref_valid)
                ref_line <= {ref_line[MAX_DELAY-2:1], i_ref_bit};
        end
    end

    assign o_locked    = state_q == LOCKED;
    assign o_delay     = dly_q;
    assign o_bit_count = bits_q;
    assign o_err_count = errs_q;
endmodule

// File: tb/tb_ber_symbol_checker.sv
// tb_ber_symbol_checker: directed scenarios against a PRBS9 reference delayed by three symbols.
module tb_ber_symbol_checker;
    localparam int OS = 4;
    localparam logic [63:0] ONES = '1;

    logic clk = 1'b0;
    logic i_reset, i_enable, i_ref_bit, i_ref_valid, i_clear;
    logic signed [7:0] i_os_data;
    logic [1:0] i_phase, i_phase_sel;
    logic o_locked;
    logic [8:0] o_delay;
    logic [63:0] o_bit_count, o_err_count;
    int checks = 0, failures = 0, k = 0;
    logic [8:0] lfsr = 9'h1FF;
    logic [2:0] h = '0;
    logic [63:0] b0, e0;
    logic [8:0] d0;

    ber_symbol_checker dut (
        .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_os_data(i_os_data),
        .i_phase(i_phase), .i_phase_sel(i_phase_sel), .i_ref_bit(i_ref_bit),
        .i_ref_valid(i_ref_valid), .i_clear(i_clear), .o_locked(o_locked),
        .o_delay(o_delay), .o_bit_count(o_bit_count), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [7:0] sample(input logic b, input int n);
        return b ? 8'(-1 - (n % 128)) : 8'(n % 128);
    endfunction

    // Decision = reference from three symbols ago, optionally inverted every Nth or always.
    task automatic run(input int nsym, input bit four, input int every, input bit inv);
        logic cur, bad, dbit;
        for (int s = 0; s < nsym; s++) begin
            cur  = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], cur};
            bad  = inv || (every != 0 && s % every == every - 1);
            dbit = h[2] ^ bad;
            k++;
            if (four) begin
                for (int p = 0; p < OS; p++) begin
                    i_phase     = 2'(p);
                    i_ref_valid = (2'(p) == i_phase_sel);
                    i_ref_bit   = cur;
                    i_os_data   = sample(i_ref_valid ? dbit : !dbit, k + p);
                    tick;
                end
            end else begin
                i_phase     = i_phase_sel;
                i_ref_valid = 1'b1;
                i_ref_bit   = cur;
                i_os_data   = sample(dbit, k);
                tick;
            end
            h = {h[1:0], cur};
        end
        i_ref_valid = 1'b0;
        i_phase     = i_phase_sel ^ 2'b01;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        tick;
        tick;
        i_reset = 1'b0;
        checks += 4;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0d exp=0", o_locked); end
        if (o_delay !== 9'd0) begin failures++; $display("FAIL reset_delay got=%0d exp=0", o_delay); end
        if (o_bit_count !== 64'd0) begin failures++; $display("FAIL reset_bits got=%0d exp=0", o_bit_count); end
        if (o_err_count !== 64'd0) begin failures++; $display("FAIL reset_errs got=%0d exp=0", o_err_count); end
    endtask

    task automatic test_align;
        run(511, 1'b1, 0, 1'b0);
        checks += 2;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL align_early_lock got=%0d exp=0", o_locked); end
        if (o_delay !== 9'd3) begin failures++; $display("FAIL align_delay_pre got=%0d exp=3", o_delay); end
        run(1, 1'b1, 0, 1'b0);
        checks += 3;
        if (o_locked !== 1'b1) begin failures++; $display("FAIL align_lock got=%0d exp=1", o_locked); end
        if (o_delay !== 9'd3) begin failures++; $display("FAIL align_delay got=%0d exp=3", o_delay); end
        if (o_bit_count !== 64'd0) begin failures++; $display("FAIL align_lock_edge_bits got=%0d exp=0", o_bit_count); end
        run(1000, 1'b1, 0, 1'b0);
        checks += 2;
        if (o_bit_count !== 64'd1000) begin failures++; $display("FAIL align_bits got=%0d exp=1000", o_bit_count); end
        if (o_err_count !== 64'd0) begin failures++; $display("FAIL align_errs got=%0d exp=0", o_err_count); end
    endtask

    task automatic test_errors;
        run(1000, 1'b0, 10, 1'b0);
        checks += 3;
        if (o_bit_count !== 64'd2000) begin failures++; $display("FAIL err_bits got=%0d exp=2000", o_bit_count); end
        if (o_err_count !== 64'd100) begin failures++; $display("FAIL err_errs got=%0d exp=100", o_err_count); end
        if (o_locked !== 1'b1) begin failures++; $display("FAIL err_locked got=%0d exp=1", o_locked); end
    endtask

    task automatic test_phase_sel;
        i_phase_sel = 2'd1;
        run(20, 1'b1, 0, 1'b0);
        i_phase_sel = 2'd2;
        checks += 2;
        if (o_bit_count !== 64'd2020) begin failures++; $display("FAIL phase_bits got=%0d exp=2020", o_bit_count); end
        if (o_err_count !== 64'd100) begin failures++; $display("FAIL phase_errs got=%0d exp=100", o_err_count); end
    endtask

    task automatic test_enable;
        b0 = o_bit_count;
        e0 = o_err_count;
        d0 = o_delay;
        i_enable = 1'b0;
        for (int c = 0; c < 50; c++) begin
            i_phase     = i_phase_sel;
            i_ref_valid = 1'b1;
            i_ref_bit   = 1'(c);
            i_os_data   = -8'sd50;
            tick;
        end
        i_ref_valid = 1'b0;
        checks += 4;
        if (o_bit_count !== b0) begin failures++; $display("FAIL hold_bits got=%0d exp=%0d", o_bit_count, b0); end
        if (o_err_count !== e0) begin failures++; $display("FAIL hold_errs got=%0d exp=%0d", o_err_count, e0); end
        if (o_delay !== d0) begin failures++; $display("FAIL hold_delay got=%0d exp=%0d", o_delay, d0); end
        if (o_locked !== 1'b1) begin failures++; $display("FAIL hold_locked got=%0d exp=1", o_locked); end
        i_enable = 1'b1;
        run(10, 1'b0, 0, 1'b0);
        checks += 2;
        if (o_bit_count !== 64'd2030) begin failures++; $display("FAIL resume_bits got=%0d exp=2030", o_bit_count); end
        if (o_err_count !== 64'd100) begin failures++; $display("FAIL resume_errs got=%0d exp=100", o_err_count); end
    endtask

    task automatic test_saturation;
        i_enable = 1'b0;
        force dut.bits_q = ONES - 64'd3;
        tick;
        release dut.bits_q;
        i_enable = 1'b1;
        run(5, 1'b0, 0, 1'b0);
        checks += 2;
        if (o_bit_count !== ONES) begin failures++; $display("FAIL sat_bits got=%0h exp=%0h", o_bit_count, ONES); end
        if (o_err_count !== 64'd100) begin failures++; $display("FAIL sat_errs_unaffected got=%0d exp=100", o_err_count); end
        i_enable = 1'b0;
        force dut.errs_q = ONES - 64'd1;
        tick;
        release dut.errs_q;
        i_enable = 1'b1;
        run(3, 1'b0, 0, 1'b1);
        checks += 3;
        if (o_err_count !== ONES) begin failures++; $display("FAIL sat_errs got=%0h exp=%0h", o_err_count, ONES); end
        if (o_bit_count !== ONES) begin failures++; $display("FAIL sat_bits_hold got=%0h exp=%0h", o_bit_count, ONES); end
        if (o_locked !== 1'b1) begin failures++; $display("FAIL sat_locked got=%0d exp=1", o_locked); end
    endtask

    task automatic test_clear;
        i_clear = 1'b1;
        run(1, 1'b0, 0, 1'b1);
        i_clear = 1'b0;
        checks += 4;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL clr_locked got=%0d exp=0", o_locked); end
        if (o_delay !== 9'd0) begin failures++; $display("FAIL clr_delay got=%0d exp=0", o_delay); end
        if (o_bit_count !== 64'd0) begin failures++; $display("FAIL clr_bits got=%0d exp=0", o_bit_count); end
        if (o_err_count !== 64'd0) begin failures++; $display("FAIL clr_errs got=%0d exp=0", o_err_count); end
        run(511, 1'b0, 0, 1'b0);
        checks++;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%0d exp=0", o_locked); end
        run(1, 1'b0, 0, 1'b0);
        checks += 2;
        if (o_locked !== 1'b1) begin failures++; $display("FAIL relock got=%0d exp=1", o_locked); end
        if (o_delay !== 9'd3) begin failures++; $display("FAIL relock_delay got=%0d exp=3", o_delay); end
    endtask

    task automatic test_reset_locked;
        run(5, 1'b0, 2, 1'b0);
        checks += 2;
        if (o_bit_count !== 64'd5) begin failures++; $display("FAIL pre_rst_bits got=%0d exp=5", o_bit_count); end
        if (o_err_count !== 64'd2) begin failures++; $display("FAIL pre_rst_errs got=%0d exp=2", o_err_count); end
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        checks += 4;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0d exp=0", o_locked); end
        if (o_delay !== 9'd0) begin failures++; $display("FAIL rst_delay got=%0d exp=0", o_delay); end
        if (o_bit_count !== 64'd0) begin failures++; $display("FAIL rst_bits got=%0d exp=0", o_bit_count); end
        if (o_err_count !== 64'd0) begin failures++; $display("FAIL rst_errs got=%0d exp=0", o_err_count); end
    endtask

    task automatic test_nolock;
        run(128, 1'b0, 0, 1'b1);
        checks += 2;
        if (o_delay !== 9'd1) begin failures++; $display("FAIL nolock_d1 got=%0d exp=1", o_delay); end
        if (o_locked !== 1'b0) begin failures++; $display("FAIL nolock_l1 got=%0d exp=0", o_locked); end
        run(128, 1'b0, 0, 1'b1);
        checks++;
        if (o_delay !== 9'd2) begin failures++; $display("FAIL nolock_d2 got=%0d exp=2", o_delay); end
        i_enable = 1'b0;
        force dut.dly_q = 9'd510;
        tick;
        release dut.dly_q;
        i_enable = 1'b1;
        run(128, 1'b0, 0, 1'b1);
        checks++;
        if (o_delay !== 9'd511) begin failures++; $display("FAIL nolock_d511 got=%0d exp=511", o_delay); end
        run(128, 1'b0, 0, 1'b1);
        checks += 2;
        if (o_delay !== 9'd0) begin failures++; $display("FAIL nolock_wrap got=%0d exp=0", o_delay); end
        if (o_locked !== 1'b0) begin failures++; $display("FAIL nolock_locked got=%0d exp=0", o_locked); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_enable = 1'b1;
        i_clear = 1'b0;
        i_phase = 2'd0;
        i_phase_sel = 2'd2;
        i_ref_bit = 1'b0;
        i_ref_valid = 1'b0;
        i_os_data = '0;
        test_reset;
        test_align;
        test_errors;
        test_phase_sel;
        test_enable;
        test_saturation;
        test_clear;
        test_reset_locked;
        test_nolock;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
